// File: rtl/div_bcd_formatter_pkg.sv
// Shared types and constants for the divider BCD formatter.
// DIV_BCD_ASCII_EN adds ASCII views of both results.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int ITER_CNT = 8;
    localparam int BIN_W = 8;
    localparam int BCD_W = 12;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    function automatic logic [23:0] bcd_to_ascii(
        input logic [BCD_W-1:0] b
    );
        return {ASCII_ZERO + {4'h0, b[11:8]},
                ASCII_ZERO + {4'h0, b[7:4]},
                ASCII_ZERO + {4'h0, b[3:0]}};
    endfunction

endpackage

// File: rtl/div_bcd_formatter_if.sv
// Operand and result handshakes of the BCD formatter.
// DIV_BCD_ASCII_EN adds the ASCII result signals.
interface div_bcd_formatter_if;
    import div_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [BIN_W-1:0] q;
    logic [BIN_W-1:0] r;
    logic             out_valid;
    logic             out_ready;
    logic [BCD_W-1:0] q_bcd;
    logic [BCD_W-1:0] r_bcd;
    logic             busy;
`ifdef DIV_BCD_ASCII_EN
    logic [23:0]      q_ascii;
    logic [23:0]      r_ascii;
`endif

    modport master (
`ifdef DIV_BCD_ASCII_EN
        input  q_ascii, r_ascii,
`endif
        output in_valid, q, r, out_ready,
        input  in_ready, out_valid, q_bcd, r_bcd, busy
    );

    modport slave (
`ifdef DIV_BCD_ASCII_EN
        output q_ascii, r_ascii,
`endif
        input  in_valid, q, r, out_ready,
        output in_ready, out_valid, q_bcd, r_bcd, busy
    );

endinterface

// File: rtl/div_bcd_formatter_dd_step.sv
// One combinational double-dabble step: add-3 correction, then shift.
module dd_step
    import div_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_in,
    input  logic [BIN_W-1:0] bin_in,
    output logic [BCD_W-1:0] bcd_out,
    output logic [BIN_W-1:0] bin_out
);

    logic [BCD_W-1:0] adj;

    always_comb begin
        adj = bcd_in;
        for (int i = 0; i < 3; i++) begin
            if (bcd_in[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
        end
    end

    assign {bcd_out, bin_out} = {adj[BCD_W-2:0], bin_in, 1'b0};

endmodule

// File: rtl/div_bcd_formatter.sv
// Captures quotient/remainder and converts both to packed BCD, one bit per clock.
// DIV_BCD_ASCII_EN adds registered ASCII copies of the results.
module div_bcd_formatter
    import div_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    div_bcd_formatter_if.slave   bus
);

    state_t           state;
    state_t           nxt;
    logic [2:0]       cnt;
    logic [BIN_W-1:0] q_bin, r_bin, q_bin_n, r_bin_n;
    logic [BCD_W-1:0] q_acc, r_acc, q_acc_n, r_acc_n;
    logic [BCD_W-1:0] q_res, r_res;
    logic             last;

    dd_step u_q (
        .bcd_in (q_acc),
        .bin_in (q_bin),
        .bcd_out(q_acc_n),
        .bin_out(q_bin_n)
    );

    dd_step u_r (
        .bcd_in (r_acc),
        .bin_in (r_bin),
        .bcd_out(r_acc_n),
        .bin_out(r_bin_n)
    );

    assign last = (cnt == 3'(ITER_CNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (bus.in_valid)  nxt = SHIFT;
            SHIFT:   if (last)          nxt = DONE;
            DONE:    if (bus.out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Results live in their own registers so they hold through the next conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            q_bin <= '0;
            r_bin <= '0;
            q_acc <= '0;
            r_acc <= '0;
            q_res <= '0;
            r_res <= '0;
        end else begin
            if (state == IDLE && bus.in_valid) begin
                q_bin <= bus.q;
                r_bin <= bus.r;
                q_acc <= '0;
                r_acc <= '0;
                cnt   <= '0;
            end else if (state == SHIFT) begin
                q_bin <= q_bin_n;
                r_bin <= r_bin_n;
                q_acc <= q_acc_n;
                r_acc <= r_acc_n;
                cnt   <= cnt + 3'd1;
                if (last) begin
                    q_res <= q_acc_n;
                    r_res <= r_acc_n;
                end
            end
        end
    end

`ifdef DIV_BCD_ASCII_EN
    logic [23:0] q_asc, r_asc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_asc <= {3{ASCII_ZERO}};
            r_asc <= {3{ASCII_ZERO}};
        end else if (state == SHIFT && last) begin
            q_asc <= bcd_to_ascii(q_acc_n);
            r_asc <= bcd_to_ascii(r_acc_n);
        end
    end

    assign bus.q_ascii = q_asc;
    assign bus.r_ascii = r_asc;
`endif

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.q_bcd     = q_res;
    assign bus.r_bcd     = r_res;

endmodule

// File: tb/tb_div_bcd_formatter.sv
// Scoreboard bench for div_bcd_formatter against a decimal-arithmetic model.
module tb_div_bcd_formatter;
    import div_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    div_bcd_formatter_if bus ();

    div_bcd_formatter dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int qv;
        int rv;
        int acc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rdy_mode = 0;
    bit chk_idle = 0;
    bit prev_v = 0;

    always @(posedge clk) cyc++;

    function automatic logic [11:0] ref_bcd(int v);
        return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + v % 10);
    endfunction

    function automatic logic [23:0] ref_ascii(int v);
        return {8'(48 + v / 100), 8'(48 + (v / 10) % 10), 8'(48 + v % 10)};
    endfunction

    task automatic check(string n, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.out_ready = 1'($urandom_range(0, 1));
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 0;
            chk_idle = 0;
        end else begin
            if (chk_idle) begin
                check("in_ready_after_handshake", 32'(bus.in_ready), 32'd1);
                chk_idle = 0;
            end
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
                end else begin
                    e = sb[0];
                    check("q_bcd", 32'(bus.q_bcd), 32'(ref_bcd(e.qv)));
                    check("r_bcd", 32'(bus.r_bcd), 32'(ref_bcd(e.rv)));
                    check("in_ready_in_done", 32'(bus.in_ready), 32'd0);
                    check("busy_in_done", 32'(bus.busy), 32'd1);
`ifdef DIV_BCD_ASCII_EN
                    check("q_ascii", 32'(bus.q_ascii), 32'(ref_ascii(e.qv)));
                    check("r_ascii", 32'(bus.r_ascii), 32'(ref_ascii(e.rv)));
`endif
                    if (!prev_v) check("latency", 32'(cyc - e.acc), 32'd8);
                    if (bus.out_ready) begin
                        void'(sb.pop_front());
                        chk_idle = 1;
                    end
                end
            end
            prev_v = bus.out_valid;
        end
    end

    task automatic send(int qv, int rv);
        int n = 0;
        bit done = 0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.q = 8'(qv);
        bus.r = 8'(rv);
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back('{qv, rv, cyc + 1});
                done = 1;
            end else if (++n > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_timeout: got no in_ready, required 1");
                done = 1;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bit done = 0;
        while (!done) begin
            @(negedge clk);
            if (sb.size() == 0 && bus.in_ready) begin
                done = 1;
            end else if (++n > 300) begin
                vectors++;
                miscompares++;
                $display("FAIL drain_timeout: got %0d pending, required 0",
                         sb.size());
                done = 1;
            end
        end
    endtask

    task automatic check_reset_state();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_q_bcd", 32'(bus.q_bcd), 32'd0);
        check("rst_r_bcd", 32'(bus.r_bcd), 32'd0);
`ifdef DIV_BCD_ASCII_EN
        check("rst_q_ascii", 32'(bus.q_ascii), 32'h303030);
        check("rst_r_ascii", 32'(bus.r_ascii), 32'h303030);
`endif
    endtask

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.q = '0;
        bus.r = '0;
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_state();
        @(negedge clk);
        rst_n = 1'b1;

        rdy_mode = 2;
        send(3, 10);
        drain();
        send(0, 12);
        drain();
        send(255, 199);
        drain();

        rdy_mode = 1;
        send(123, 45);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid_seen", 32'(bus.out_valid), 32'd1);
        repeat (5) @(negedge clk);
        rdy_mode = 2;
        drain();

        send(40, 7);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.q = 8'd77;
        bus.r = 8'd77;
        repeat (3) begin
            @(negedge clk);
            check("in_ready_in_shift", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain();

        rdy_mode = 0;
        repeat (40) begin
            send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        drain();

        rdy_mode = 2;
        send(255, 255);
        drain();
        send(200, 100);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_state();
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(9, 5);
        drain();

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
